// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the DMA/word FIFO and the chain loader.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer: serialises bitstream words into ccff_head and
// optionally recirculates the chain through ccff_tail to check it with CRC-16-CCITT.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W,
  localparam int unsigned CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  ccff_chain_loader_if.slave bs,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam logic [CW-1:0] LastIdx   = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] ChainLenC = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] NumWordsC = CW'(NUM_WORDS);
  localparam logic [15:0]   CrcSeed   = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e            state_q, state_d;
  logic              verify_q, verify_d;
  logic              crc_err_q, crc_err_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CW-1:0]     bits_left_q, bits_left_d;
  logic [CW-1:0]     shifted_q, shifted_d;
  logic [CW-1:0]     words_q, words_d;
  logic [CW-1:0]     vcnt_q, vcnt_d;
  logic [CW-1:0]     remain;
  logic [15:0]       load_crc_q, load_crc_d;
  logic [15:0]       rb_crc_q, rb_crc_d;
  logic              s_ready_c;
  logic              accept;

  // Bit-serial CRC-16-CCITT step, MSB feedback, poly 0x1021.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign bs.s_ready = s_ready_c;
  assign accept     = bs.s_valid & s_ready_c;
  assign crc_err    = crc_err_q;

  // State register.
  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad: begin
        if (config_enable && shifted_q == LastIdx) begin
          state_d = verify_q ? StVerify : StDone;
        end
      end
      StVerify: if (vcnt_q == LastIdx) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; verify loops tail straight back to head.
  always_comb begin
    s_ready_c     = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StLoad: begin
        busy          = 1'b1;
        config_enable = (bits_left_q != '0);
        ccff_head     = (bits_left_q != '0) & buf_q[0];
        s_ready_c     = (bits_left_q <= CW'(1)) && (words_q < NumWordsC);
      end
      StVerify: begin
        busy          = 1'b1;
        config_enable = 1'b1;
        ccff_head     = ccff_tail;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: shift buffer, counters and both CRCs.
  always_comb begin
    verify_d    = verify_q;
    crc_err_d   = crc_err_q;
    buf_d       = buf_q;
    bits_left_d = bits_left_q;
    shifted_d   = shifted_q;
    words_d     = words_q;
    vcnt_d      = vcnt_q;
    load_crc_d  = load_crc_q;
    rb_crc_d    = rb_crc_q;
    remain      = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          verify_d    = verify_en;
          crc_err_d   = 1'b0;
          load_crc_d  = CrcSeed;
          rb_crc_d    = CrcSeed;
          bits_left_d = '0;
          shifted_d   = '0;
          words_d     = '0;
          vcnt_d      = '0;
        end
      end
      StLoad: begin
        if (config_enable) begin
          buf_d       = buf_q >> 1;
          bits_left_d = bits_left_q - CW'(1);
          shifted_d   = shifted_q + CW'(1);
          load_crc_d  = crc_step(load_crc_q, ccff_head);
        end
        // A word accepted on the final-bit edge replaces the buffer at that same edge.
        if (accept) begin
          buf_d   = bs.s_data;
          words_d = words_q + CW'(1);
          remain  = ChainLenC - shifted_d;
          if (32'(remain) > WORD_W) begin
            bits_left_d = CW'(WORD_W);
          end else begin
            bits_left_d = remain;
          end
        end
      end
      StVerify: begin
        rb_crc_d = crc_step(rb_crc_q, ccff_tail);
        vcnt_d   = vcnt_q + CW'(1);
        if (vcnt_q == LastIdx) crc_err_d = (load_crc_q != rb_crc_d);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      verify_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      buf_q       <= '0;
      bits_left_q <= '0;
      shifted_q   <= '0;
      words_q     <= '0;
      vcnt_q      <= '0;
      load_crc_q  <= '0;
      rb_crc_q    <= '0;
    end else begin
      verify_q    <= verify_d;
      crc_err_q   <= crc_err_d;
      buf_q       <= buf_d;
      bits_left_q <= bits_left_d;
      shifted_q   <= shifted_d;
      words_q     <= words_d;
      vcnt_q      <= vcnt_d;
      load_crc_q  <= load_crc_d;
      rb_crc_q    <= rb_crc_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a 20-flop chain model hanging off ccff_head/ccff_tail.
module tb_ccff_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = 3;

  logic prog_clock = 1'b0;
  logic prog_reset = 1'b1;
  logic start = 1'b0;
  logic verify_en = 1'b0;
  logic config_enable, ccff_head, ccff_tail, busy, done, crc_err;
  logic flip = 1'b0;
  logic [CL-1:0] chain = '0;

  ccff_chain_loader_if #(.WORD_W(WW)) bus ();

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clock    (prog_clock),
    .prog_reset    (prog_reset),
    .start         (start),
    .verify_en     (verify_en),
    .bs            (bus),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .crc_err       (crc_err)
  );

  always #5 prog_clock = ~prog_clock;

  // chain[0] is the first tile flop, chain[CL-1] drives ccff_tail.
  always @(posedge prog_clock) if (config_enable) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1] ^ flip;

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] wd [NW];
  logic heads[$];
  logic rb[$];
  int first_en, last_load_en, first_acc, low_in_span, ready_extra, loop_bad, done_cnt;
  logic crc_at_done, busy_at_done, ready_at_start, crc_err_after_start;
  bit timed_out;

  // Reference: bit k of the load is bit (k mod WW) of word k/WW; later bits are dropped.
  function automatic logic exp_bit(input int k);
    logic [WW-1:0] w;
    w = wd[k / WW];
    return w[k % WW];
  endfunction

  function automatic int content_bad(input int inj);
    int n = 0;
    for (int k = 0; k < CL; k++)
      if (chain[CL-1-k] !== (exp_bit(k) ^ (k == inj))) n++;
    return n;
  endfunction

  function automatic int heads_bad();
    int n = 0;
    if (heads.size() != CL) return CL;
    for (int k = 0; k < CL; k++) if (heads[k] !== exp_bit(k)) n++;
    return n;
  endfunction

  function automatic int rb_bad(input int inj);
    int n = 0;
    if (rb.size() != CL) return CL;
    for (int k = 0; k < CL; k++) if (rb[k] !== (exp_bit(k) ^ (k == inj))) n++;
    return n;
  endfunction

  // Drives one load (and optional verify), recording observations only.
  task automatic run_load(input bit ver, input int gap, input int inj, input int start_mid,
                          input bit sv_with_start, input int abort_after);
    int widx = 0, rdy_seen = 0, en_cnt = 0;
    bit acc_now;
    heads.delete(); rb.delete();
    first_en = -1; last_load_en = -1; first_acc = -1;
    low_in_span = 0; ready_extra = 0; loop_bad = 0; done_cnt = 0; timed_out = 1;
    @(negedge prog_clock);
    start = 1'b1; verify_en = ver;
    bus.s_valid = sv_with_start; bus.s_data = wd[0];
    #1 ready_at_start = bus.s_ready;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge prog_clock);
      start = (start_mid > 0 && en_cnt == start_mid);
      verify_en = ~ver;
      if (abort_after > 0 && en_cnt == abort_after) begin
        prog_reset = 1'b1; bus.s_valid = 1'b0; start = 1'b0; timed_out = 0;
        return;
      end
      flip = (inj >= 0 && en_cnt == CL + inj);
      if (widx < NW && (widx == 0 || rdy_seen >= gap)) begin
        bus.s_valid = 1'b1; bus.s_data = wd[widx];
      end else begin
        bus.s_valid = 1'b0; bus.s_data = WW'($urandom);
      end
      #1;
      if (cyc == 1) crc_err_after_start = crc_err;
      acc_now = bus.s_valid && bus.s_ready;
      if (acc_now) begin
        if (widx == 0) first_acc = cyc;
        widx++; rdy_seen = 0;
      end else if (widx > 0 && widx < NW && bus.s_ready) begin
        rdy_seen++;
      end
      if (!acc_now && widx >= NW && bus.s_ready) ready_extra++;
      if (config_enable) begin
        if (en_cnt == 0) first_en = cyc;
        if (en_cnt < CL) begin
          heads.push_back(ccff_head); last_load_en = cyc;
        end else begin
          rb.push_back(ccff_tail);
          if (ccff_head !== ccff_tail) loop_bad++;
        end
        en_cnt++;
      end else if (en_cnt > 0 && en_cnt < CL) begin
        low_in_span++;
      end
      if (done) begin
        done_cnt++; crc_at_done = crc_err; busy_at_done = busy; timed_out = 0;
        break;
      end
    end
    start = 1'b0; bus.s_valid = 1'b0; flip = 1'b0;
  endtask

  task automatic test_reset();
    prog_reset = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (2) @(negedge prog_clock);
    #1;
    checks++;
    if ({config_enable, bus.s_ready, ccff_head, busy, done, crc_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000",
               {config_enable, bus.s_ready, ccff_head, busy, done, crc_err});
    end
    prog_reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'h0F;
    run_load(1'b0, 0, -1, 0, 1'b0, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL b2b_timeout got=1 want=0"); end
    checks++; if (heads_bad() != 0) begin failures++; $display("FAIL b2b_heads bad=%0d want=0", heads_bad()); end
    checks++; if (first_en != first_acc + 1) begin failures++; $display("FAIL b2b_first_en got=%0d want=%0d", first_en, first_acc + 1); end
    checks++; if (last_load_en - first_en + 1 != CL) begin failures++; $display("FAIL b2b_contig span=%0d want=%0d", last_load_en - first_en + 1, CL); end
    checks++; if (ready_extra != 0) begin failures++; $display("FAIL b2b_no_4th_ready got=%0d want=0", ready_extra); end
    checks++; if (done_cnt != 1 || crc_at_done !== 1'b0 || busy_at_done !== 1'b0) begin failures++; $display("FAIL b2b_done cnt=%0d crc=%b busy=%b want 1/0/0", done_cnt, crc_at_done, busy_at_done); end
    checks++; if (rb.size() != 0) begin failures++; $display("FAIL b2b_no_verify got=%0d want=0", rb.size()); end
    checks++; if (content_bad(-1) != 0) begin failures++; $display("FAIL b2b_content bad=%0d want=0", content_bad(-1)); end
    @(negedge prog_clock); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done_once done=%b busy=%b want=0/0", done, busy); end
  endtask

  task automatic test_stalled();
    wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'h0F;
    run_load(1'b0, 3, -1, 0, 1'b0, 0);
    checks++; if (timed_out || heads_bad() != 0) begin failures++; $display("FAIL stall_heads bad=%0d timeout=%0d want=0", heads_bad(), timed_out); end
    checks++; if (low_in_span != 2 * 3) begin failures++; $display("FAIL stall_gaps got=%0d want=%0d", low_in_span, 2 * 3); end
    checks++; if (content_bad(-1) != 0 || done_cnt != 1) begin failures++; $display("FAIL stall_content bad=%0d done=%0d want=0/1", content_bad(-1), done_cnt); end
  endtask

  task automatic test_verify_good();
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b1, int'($urandom_range(0, 2)), -1, 0, 1'b0, 0);
    checks++; if (timed_out || heads_bad() != 0) begin failures++; $display("FAIL ver_heads bad=%0d want=0", heads_bad()); end
    checks++; if (rb.size() != CL || loop_bad != 0) begin failures++; $display("FAIL ver_loop n=%0d bad=%0d want=%0d/0", rb.size(), loop_bad, CL); end
    checks++; if (rb_bad(-1) != 0) begin failures++; $display("FAIL ver_order bad=%0d want=0", rb_bad(-1)); end
    checks++; if (crc_at_done !== 1'b0 || content_bad(-1) != 0) begin failures++; $display("FAIL ver_crc crc=%b content_bad=%0d want=0/0", crc_at_done, content_bad(-1)); end
  endtask

  task automatic test_fault();
    int inj = int'($urandom_range(0, CL - 1));
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b1, 0, inj, 0, 1'b0, 0);
    checks++; if (timed_out || crc_at_done !== 1'b1) begin failures++; $display("FAIL fault_crc_err got=%b want=1 inj=%0d", crc_at_done, inj); end
    checks++; if (rb_bad(inj) != 0) begin failures++; $display("FAIL fault_readback bad=%0d want=0", rb_bad(inj)); end
    repeat (4) @(negedge prog_clock);
    #1;
    checks++; if (crc_err !== 1'b1) begin failures++; $display("FAIL fault_hold got=%b want=1", crc_err); end
    run_load(1'b0, 0, -1, 0, 1'b0, 0);
    checks++; if (crc_err_after_start !== 1'b0 || crc_at_done !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b/%b want=0/0", crc_err_after_start, crc_at_done); end
  endtask

  task automatic test_reset_mid();
    int late_done = 0;
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b1, 0, -1, 0, 1'b0, 7);
    @(negedge prog_clock); #1;
    checks++;
    if ({config_enable, bus.s_ready, busy, done} !== 4'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b want=0000", {config_enable, bus.s_ready, busy, done});
    end
    prog_reset = 1'b0;
    repeat (5) begin @(negedge prog_clock); #1; if (done) late_done++; end
    checks++; if (late_done != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", late_done); end
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b0, 1, -1, 0, 1'b0, 0);
    checks++; if (timed_out || heads_bad() != 0 || done_cnt != 1) begin failures++; $display("FAIL rstmid_reload bad=%0d done=%0d want=0/1", heads_bad(), done_cnt); end
  endtask

  task automatic test_guards();
    int idle_acc = 0;
    @(negedge prog_clock);
    bus.s_valid = 1'b1; bus.s_data = 8'hFF;
    repeat (5) begin @(negedge prog_clock); #1; if (bus.s_ready || config_enable) idle_acc++; end
    bus.s_valid = 1'b0;
    checks++; if (idle_acc != 0) begin failures++; $display("FAIL guard_idle_valid got=%0d want=0", idle_acc); end
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b0, 0, -1, 5, 1'b0, 0);
    checks++; if (timed_out || heads_bad() != 0 || done_cnt != 1 || rb.size() != 0) begin failures++; $display("FAIL guard_start_busy bad=%0d done=%0d rb=%0d want=0/1/0", heads_bad(), done_cnt, rb.size()); end
    for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
    run_load(1'b0, 0, -1, 0, 1'b1, 0);
    checks++; if (ready_at_start !== 1'b0 || first_acc != 1) begin failures++; $display("FAIL guard_start_valid ready=%b acc=%0d want=0/1", ready_at_start, first_acc); end
    checks++; if (heads_bad() != 0) begin failures++; $display("FAIL guard_start_valid_heads bad=%0d want=0", heads_bad()); end
  endtask

  task automatic test_random();
    bit ver;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NW; i++) wd[i] = WW'($urandom);
      ver = 1'($urandom);
      run_load(ver, int'($urandom_range(0, 4)), -1, 0, 1'b0, 0);
      checks++;
      if (timed_out || heads_bad() != 0 || done_cnt != 1 || crc_at_done !== 1'b0 ||
          rb.size() != (ver ? CL : 0) || content_bad(-1) != 0) begin
        failures++;
        $display("FAIL rand_%0d heads_bad=%0d done=%0d crc=%b rb=%0d content_bad=%0d",
                 it, heads_bad(), done_cnt, crc_at_done, rb.size(), content_bad(-1));
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    test_reset();
    test_back_to_back();
    test_stalled();
    test_verify_good();
    test_fault();
    test_reset_mid();
    test_guards();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
